// File: rtl/multicycle_rca.sv
// multicycle_rca: WIDTH-bit a+b+cin, CHUNK bits per clock through a registered carry; MULTICYCLE_RCA_OVF_EN adds signed overflow.
// Latency: out_valid N=WIDTH/CHUNK cycles after accept; one result per N+2 cycles with out_ready held high.
// Backpressure: sum/cout/ovf/out_valid hold while out_ready is low; in_ready is high only in IDLE.
module multicycle_rca #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("multicycle_rca: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_d;
  logic [CHUNK:0]    chunk_sum;
  logic [31:0]       base;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = 1'b0;
    base      = 32'(idx_q) * CHUNK;
    chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = chunk_sum[CHUNK];
          // Sign of the finished sum comes from sum_d: the top chunk lands this cycle.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef MULTICYCLE_RCA_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == BUSY && idx_q == LAST_IDX) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
  assign ovf        = 1'b0;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_multicycle_rca.sv
// Scoreboard bench for multicycle_rca (WIDTH=32, CHUNK=8, N=4).
module tb_multicycle_rca;

  localparam int N = 4;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  res_t exp_q[$];

  multicycle_rca #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
    res_t        r;
    logic [32:0] t;
    t      = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
    r.sum  = t[31:0];
    r.cout = t[32];
`ifdef MULTICYCLE_RCA_OVF_EN
    r.ovf  = (ma[31] == mb[31]) && (t[31] != ma[31]);
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  // Push the expected result, hand the operands over, and wait for out_valid.
  task automatic transact(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                          output int lat, output bit timed_out);
    int k;
    k = -1;
    exp_q.push_back(model(ta, tb_v, tc));
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin k = cyc + 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    timed_out = !out_valid || (k < 0);
    lat       = cyc - k;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (sum !== 32'd0) begin n_fail++; $display("FAIL reset_sum got=%h want=0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b want=0", cout); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add;
    int lat; bit to; res_t e;
    out_ready = 1'b1;
    transact(32'h0000_0001, 32'h0000_0002, 1'b0, lat, to);
    e = exp_q.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got=%b want=0", to); end
    n_cmp++; if (lat !== N) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, N); end
    n_cmp++; if (sum !== e.sum) begin n_fail++; $display("FAIL basic_sum got=%h want=%h", sum, e.sum); end
    n_cmp++; if (cout !== e.cout) begin n_fail++; $display("FAIL basic_cout got=%b want=%b", cout, e.cout); end
    n_cmp++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL basic_ovf got=%b want=%b", ovf, e.ovf); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_handshake got=%b want=0", out_valid); end
  endtask

  task automatic test_carry_ripple;
    int lat; bit to; res_t e;
    transact(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat, to);
    e = exp_q.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL ripple_timeout got=%b want=0", to); end
    n_cmp++; if (lat !== N) begin n_fail++; $display("FAIL ripple_latency got=%0d want=%0d", lat, N); end
    n_cmp++; if (sum !== e.sum) begin n_fail++; $display("FAIL ripple_sum got=%h want=%h", sum, e.sum); end
    n_cmp++; if (cout !== e.cout) begin n_fail++; $display("FAIL ripple_cout got=%b want=%b", cout, e.cout); end
    n_cmp++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL ripple_ovf got=%b want=%b", ovf, e.ovf); end
    @(negedge clk);
  endtask

  task automatic test_signed_overflow;
    int lat; bit to; res_t e;
    transact(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, to);
    e = exp_q.pop_front();
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL ovf_timeout got=%b want=0", to); end
    n_cmp++; if (sum !== e.sum) begin n_fail++; $display("FAIL ovf_sum got=%h want=%h", sum, e.sum); end
    n_cmp++; if (cout !== e.cout) begin n_fail++; $display("FAIL ovf_cout got=%b want=%b", cout, e.cout); end
    n_cmp++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL ovf_flag got=%b want=%b", ovf, e.ovf); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int k; bit seen; res_t e;
    k = -1; seen = 1'b0;
    out_ready = 1'b0;
    exp_q.push_back(model(32'h1234_5678, 32'h1111_1111, 1'b0));
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin k = cyc + 1; break; end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_busy_in_ready got=%b want=0", in_ready); end
      a = $urandom; b = $urandom; cin = 1'($urandom); in_valid = ~in_valid;
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b want=1", seen); end
    n_cmp++; if (cyc - k !== N) begin n_fail++; $display("FAIL bp_latency got=%0d want=%0d", cyc - k, N); end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (sum !== e.sum) begin n_fail++; $display("FAIL bp_sum_hold got=%h want=%h", sum, e.sum); end
      n_cmp++; if (cout !== e.cout) begin n_fail++; $display("FAIL bp_cout_hold got=%b want=%b", cout, e.cout); end
      n_cmp++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL bp_ovf_hold got=%b want=%b", ovf, e.ovf); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold got=%b want=1", out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_done_in_ready got=%b want=0", in_ready); end
      a = $urandom; b = $urandom; in_valid = ~in_valid;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (sum !== e.sum) begin n_fail++; $display("FAIL bp_sum_after got=%h want=%h", sum, e.sum); end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (sum !== 32'd0) begin n_fail++; $display("FAIL midrst_sum got=%h want=0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL midrst_cout got=%b want=0", cout); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf got=%b want=0", ovf); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_valid got=%b want=0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_ready got=%b want=1", in_ready); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic        pc [3];
    int          acc [3];
    int          sent, got;
    bit          adv;
    res_t        e;
    pa[0] = 32'hDEAD_BEEF; pb[0] = 32'h2152_4111; pc[0] = 1'b1;
    pa[1] = 32'h8000_0000; pb[1] = 32'h8000_0000; pc[1] = 1'b0;
    pa[2] = 32'h00FF_00FF; pb[2] = 32'h0001_0001; pc[2] = 1'b1;
    sent = 0; got = 0; adv = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    a = pa[0]; b = pb[0]; cin = pc[0]; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (adv) begin
        adv = 1'b0;
        if (sent < 3) begin a = pa[sent]; b = pb[sent]; cin = pc[sent]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        e = exp_q.pop_front();
        got++;
        n_cmp++; if (sum !== e.sum) begin n_fail++; $display("FAIL b2b_sum[%0d] got=%h want=%h", got, sum, e.sum); end
        n_cmp++; if (cout !== e.cout) begin n_fail++; $display("FAIL b2b_cout[%0d] got=%b want=%b", got, cout, e.cout); end
        n_cmp++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL b2b_ovf[%0d] got=%b want=%b", got, ovf, e.ovf); end
      end
      if (in_valid && in_ready && sent < 3) begin
        acc[sent] = cyc + 1;
        exp_q.push_back(model(pa[sent], pb[sent], pc[sent]));
        sent++;
        adv = 1'b1;
      end
      if (got == 3) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL b2b_results got=%0d want=3", got); end
    if (sent == 3) begin
      n_cmp++; if (acc[1] - acc[0] !== N + 2) begin n_fail++; $display("FAIL b2b_gap01 got=%0d want=%0d", acc[1] - acc[0], N + 2); end
      n_cmp++; if (acc[2] - acc[1] !== N + 2) begin n_fail++; $display("FAIL b2b_gap12 got=%0d want=%0d", acc[2] - acc[1], N + 2); end
    end else begin
      n_cmp++; n_fail++; $display("FAIL b2b_accepts got=%0d want=3", sent);
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_queue_left got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_signed_overflow();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
